// File: rtl/maze_pkg.sv
// maze_pkg: shared maze geometry, cell codes and streamer state encoding
package maze_pkg;
    localparam int COLS     = 64;
    localparam int ROWS     = 64;
    localparam int ROW_BITS = 2 * COLS;

    localparam logic [1:0] OUT      = 2'b00;
    localparam logic [1:0] WALL     = 2'b01;
    localparam logic [1:0] FRONTIER = 2'b10;
    localparam logic [1:0] PATH     = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_FINISH, STREAM, DONE} state_t;
endpackage

// File: rtl/maze_cell_mux.sv
// maze_cell_mux: combinational 2-bit cell select from the packed maze bitmap
module maze_cell_mux #(
    parameter int CX_W = 6,
    parameter int CY_W = 6
) (
    input  logic [(2**(CX_W+CY_W+1))-1:0] maze_data,
    input  logic [CX_W-1:0]               x,
    input  logic [CY_W-1:0]               y,
    output logic [1:0]                    code
);
    // Rows are a power-of-two bits wide, so the bit index is a plain concatenation
    assign code = maze_data[{y, x, 1'b0} +: 2];
endmodule

// File: rtl/maze_cell_streamer.sv
// maze_cell_streamer: streams every maze cell row-major over valid/ready and counts PATH cells
module maze_cell_streamer #(
    parameter int COLS     = maze_pkg::COLS,
    parameter int ROWS     = maze_pkg::ROWS,
    parameter int ROW_BITS = maze_pkg::ROW_BITS,
    parameter int CX_W     = 6,
    parameter int CY_W     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     carve_finish,
    input  logic [ROWS*ROW_BITS-1:0] maze_data,
    output logic [CX_W-1:0]          cell_x,
    output logic [CY_W-1:0]          cell_y,
    output logic [1:0]               cell_code,
    output logic                     cell_last,
    output logic                     cell_valid,
    input  logic                     cell_ready,
    output logic                     busy,
    output logic [12:0]              path_count,
    output logic                     done
);
    import maze_pkg::*;

    state_t          state_q, state_d;
    logic [CX_W-1:0] ptr_x_q, ptr_x_d, cell_x_q, cell_x_d;
    logic [CY_W-1:0] ptr_y_q, ptr_y_d, cell_y_q, cell_y_d;
    logic [1:0]      cell_code_q, cell_code_d, mux_code;
    logic            cell_last_q, cell_last_d, cell_valid_q, cell_valid_d;
    logic            all_loaded_q, all_loaded_d, busy_q, busy_d, done_q, done_d;
    logic [12:0]     path_count_q, path_count_d;
    logic            load, xfer, at_end;

    maze_cell_mux #(.CX_W(CX_W), .CY_W(CY_W)) u_mux (
        .maze_data(maze_data),
        .x(ptr_x_q),
        .y(ptr_y_q),
        .code(mux_code)
    );

    // Next-state: output register refills on the same edge as a transfer, so no bubbles
    always_comb begin
        state_d      = state_q;
        ptr_x_d      = ptr_x_q;
        ptr_y_d      = ptr_y_q;
        cell_x_d     = cell_x_q;
        cell_y_d     = cell_y_q;
        cell_code_d  = cell_code_q;
        cell_last_d  = cell_last_q;
        cell_valid_d = cell_valid_q;
        all_loaded_d = all_loaded_q;
        path_count_d = path_count_q;
        at_end       = (ptr_x_q == CX_W'(COLS - 1)) && (ptr_y_q == CY_W'(ROWS - 1));
        xfer         = cell_valid_q && cell_ready;
        load         = (state_q == STREAM) && !all_loaded_q && (!cell_valid_q || cell_ready);
        case (state_q)
            IDLE: if (start) begin
                state_d      = WAIT_FINISH;
                ptr_x_d      = '0;
                ptr_y_d      = '0;
                all_loaded_d = 1'b0;
                path_count_d = '0;
            end
            WAIT_FINISH: if (carve_finish) state_d = STREAM;
            STREAM: begin
                if (xfer && cell_code_q == PATH) path_count_d = path_count_q + 13'd1;
                if (load) begin
                    cell_x_d     = ptr_x_q;
                    cell_y_d     = ptr_y_q;
                    cell_code_d  = mux_code;
                    cell_last_d  = at_end;
                    cell_valid_d = 1'b1;
                    all_loaded_d = at_end;
                    ptr_x_d      = ptr_x_q + 1'b1;
                    ptr_y_d      = (ptr_x_q == CX_W'(COLS - 1)) ? ptr_y_q + 1'b1 : ptr_y_q;
                end else if (xfer) begin
                    cell_valid_d = 1'b0;
                end
                if (xfer && cell_last_q) begin
                    state_d      = DONE;
                    cell_valid_d = 1'b0;
                    cell_last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT_FINISH) || (state_d == STREAM);
        done_d = (state_q == STREAM) && xfer && cell_last_q;
    end

    // State and registered outputs; reset drops any in-flight beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_x_q      <= '0;
            ptr_y_q      <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            cell_code_q  <= '0;
            cell_last_q  <= 1'b0;
            cell_valid_q <= 1'b0;
            all_loaded_q <= 1'b0;
            path_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_x_q      <= ptr_x_d;
            ptr_y_q      <= ptr_y_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            cell_code_q  <= cell_code_d;
            cell_last_q  <= cell_last_d;
            cell_valid_q <= cell_valid_d;
            all_loaded_q <= all_loaded_d;
            path_count_q <= path_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;
    assign cell_code  = cell_code_q;
    assign cell_last  = cell_last_q;
    assign cell_valid = cell_valid_q;
    assign busy       = busy_q;
    assign path_count = path_count_q;
    assign done       = done_q;
endmodule

// File: doc/maze_cell_streamer.md
Name: maze_cell_streamer

Overview:
- Reads the packed maze bitmap produced by the maze carver once the carver asserts finish.
- Emits every cell as a row-major stream of (x, y, 2-bit code) beats over a valid/ready handshake, for the display/framebuffer writer downstream.
- Counts PATH cells and pulses done after the last cell is accepted.
- Sits between the carver (writer of the bitmap) and the VGA framebuffer loader.

Parameters:
- COLS, 64, cells per row (must equal 2^CX_W)
- ROWS, 64, rows (must equal 2^CY_W)
- ROW_BITS, 128, bits per row in the bitmap (2*COLS)
- CX_W, 6, cell x index width
- CY_W, 6, cell y index width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level request to stream; sampled in IDLE only
- carve_finish  in  1  carver finish flag, level
- maze_data  in  COLS*ROWS*2  packed bitmap; cell (x,y) = maze_data[x*2 + y*ROW_BITS +: 2]
- cell_x  out  CX_W  column of current beat
- cell_y  out  CY_W  row of current beat
- cell_code  out  2  00 OUT, 01 WALL, 10 FRONTIER, 11 PATH
- cell_last  out  1  high on beat (COLS-1, ROWS-1)
- cell_valid  out  1  beat valid
- cell_ready  in  1  downstream accepts beat
- busy  out  1  high in WAIT_FINISH or STREAM
- path_count  out  13  PATH cells accepted in current/last run
- done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (reset=0, async): state=IDLE. cell_valid=0, cell_last=0, cell_x=0, cell_y=0, cell_code=0, busy=0, done=0, path_count=0. Any in-flight beat is dropped.
- IDLE -> WAIT_FINISH when start=1. On that transition, clear path_count and clear the x/y read pointers.
- WAIT_FINISH -> STREAM when carve_finish=1.
- STREAM: output register loads cell (ptr_x, ptr_y) one cycle after entry. Latency from carve_finish high to first cell_valid = 2 clocks.
- Handshake: a beat transfers when cell_valid & cell_ready are both high on a rising edge.
  - While cell_valid=1 and cell_ready=0, cell_x/cell_y/cell_code/cell_last hold stable.
  - cell_valid never drops without a transfer, except on reset.
- Throughput: with cell_ready tied high, one beat per clock. The next beat loads in the same edge as the transfer (registered pipeline, no bubble).
- Pointer advance:
  - ptr_x increments per loaded beat.
  - At ptr_x=COLS-1, ptr_x wraps to 0 and ptr_y increments.
  - After (COLS-1, ROWS-1) is loaded, no further loads occur.
- path_count increments by 1 on each transfer whose cell_code=11. 13 bits holds 4096 without overflow.
- Last-beat transfer (cell_last=1): next cycle cell_valid=0 and done=1 for exactly one cycle, then state=IDLE. path_count holds until the next start.
- busy=1 in WAIT_FINISH and STREAM; 0 otherwise, including the done cycle.
- Mid-operation conditions:
  - start high while busy: ignored.
  - start still high on return to IDLE: a new run begins the following cycle.
  - carve_finish falling during STREAM: ignored. maze_data must stay stable while busy; this is the carver's guarantee.
  - reset asserted mid-STREAM: immediate return to IDLE with all outputs at reset values.
- Codes are forwarded unmodified. The streamer never writes the bitmap.
- Cell bit select: index = {ptr_y, ptr_x, 1'b0}, since ROW_BITS=2*COLS is a power of two. Use no multipliers.

Decomposition:
- Shared package maze_pkg holds:
  - cell-code constants PATH=2'b11, OUT=2'b00, FRONTIER=2'b10, WALL=2'b01;
  - COLS, ROWS, ROW_BITS;
  - state enum {IDLE, WAIT_FINISH, STREAM, DONE}.
- The carver is migrated to the same constants.
- One sub-module, maze_cell_mux: combinational 2-bit select from maze_data given (x,y). The solver and renderer reuse it.

Test Plan:
- Reset mid-stream: reset low for 3 cycles during beat (10,3) -> cell_valid=0, busy=0, path_count=0 immediately. Next start restarts at (0,0).
- All-zero bitmap, start=1, carve_finish=1, cell_ready=1 -> cell_valid high 2 clocks after finish. Then 4096 consecutive beats, codes all 00, cell_last only at (63,63). done pulses once, path_count=0.
- Cell (0,0)=11, (63,0)=01, (0,1)=10, (63,63)=11 -> beats 0, 63, 64, 4095 carry those codes with correct x/y, including the row wrap (63,0)->(0,1). path_count=2.
- Backpressure: cell_ready low for 5 cycles at beat (5,0) -> outputs held constant all 5 cycles. Beat (5,0) transfers exactly once, and (6,0) follows.
- start=1 with carve_finish=0 for 100 cycles -> busy=1, cell_valid=0 throughout. finish rising -> stream begins 2 clocks later.
- start held high across done, with full-PATH bitmap -> path_count=4096 at done. Second run starts the cycle after IDLE, and path_count clears to 0 on that start.
